// File: rtl/main_memory.sv
// main_memory: line-granular backing store with fixed access latency.
// Define MAIN_MEMORY_BOUNDS_CHECK_EN to flag out-of-range addresses on m_error.
module main_memory #(
    parameter int Address_bits = 64,
    parameter int Data_bits    = 512,
    parameter int Depth_lines  = 1024,
    parameter int Latency      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Address_bits-1:0] m_addr,
    input  logic [Data_bits-1:0]    m_write_data,
    input  logic                    m_read_en,
    input  logic                    m_write_en,
    output logic [Data_bits-1:0]    m_read_data,
    output logic                    m_stall,
    output logic                    m_error
);
    localparam int OFF = $clog2(Data_bits / 8);
    localparam int IDX = $clog2(Depth_lines);
    localparam int CW  = $clog2(Latency + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IDX-1:0]       idx, idx_q;
    logic [Data_bits-1:0] wdata_q;
    logic [Data_bits-1:0] mem [Depth_lines];
    logic                 rd_q, wr_q, oor, oor_q, req, accept, done;

    assign req = m_read_en | m_write_en;
    assign idx = IDX'(m_addr >> OFF);
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
    assign oor = (m_addr >> (OFF + IDX)) != '0;
`else
    assign oor = 1'b0;
`endif

    // next-state: accept in IDLE, count to Latency-1 in BUSY then complete
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        done    = 1'b0;
        if (state == IDLE) begin
            accept  = req;
            cnt_n   = '0;
            state_n = req ? BUSY : IDLE;
        end else begin
            done    = cnt == CW'(Latency - 1);
            cnt_n   = cnt + CW'(1);
            state_n = done ? IDLE : BUSY;
        end
    end

    // state, stall, read data and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            m_stall     <= 1'b0;
            m_read_data <= '0;
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
            m_error     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            m_stall <= state_n == BUSY;
            if (done && rd_q)
                m_read_data <= oor_q ? '1 : wr_q ? wdata_q : mem[idx_q];
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
            if (done)
                m_error <= oor_q;
`endif
        end
    end

`ifndef MAIN_MEMORY_BOUNDS_CHECK_EN
    assign m_error = 1'b0;
`endif

    // request capture at acceptance; later enables are ignored until IDLE
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= idx;
            wdata_q <= m_write_data;
            rd_q    <= m_read_en;
            wr_q    <= m_write_en;
            oor_q   <= oor;
        end
    end

    // array write at completion; reset discards a pending write
    always_ff @(posedge clk) begin
        if (!rst && done && wr_q && !oor_q)
            mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: vector table, corner sequences and random model check for main_memory.
module tb_main_memory;
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    localparam int DB = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   m_addr;
    logic [DB-1:0] m_write_data, m_read_data;
    logic          m_read_en, m_write_en, m_stall, m_error;

    main_memory dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_write_data(m_write_data),
        .m_read_en(m_read_en), .m_write_en(m_write_en),
        .m_read_data(m_read_data), .m_stall(m_stall), .m_error(m_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]   a;
        logic [DB-1:0] d;
        logic          r;
        logic          w;
        logic [DB-1:0] exp_rd;
        logic          exp_err;
    } vec_t;
    vec_t vecs[9];

    logic [DB-1:0] model [int];
    logic [DB-1:0] m_rd;
    logic          m_err;

    task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DB-1:0] rnd();
        logic [DB-1:0] r;
        for (int i = 0; i < DB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // one request pulsed for a cycle; hi counts post-edge samples with stall high
    task automatic access(input logic [63:0] a, input logic [DB-1:0] d, input logic r,
                          input logic w, output int hi);
        @(negedge clk);
        m_addr = a; m_write_data = d; m_read_en = r; m_write_en = w;
        @(posedge clk); #1;
        m_read_en = 1'b0; m_write_en = 1'b0;
        hi = 0;
        while (m_stall && hi < 20) begin
            hi++;
            @(posedge clk); #1;
        end
    endtask

    // access checked against an address-arithmetic model of the memory
    task automatic txn(input logic [63:0] a, input logic [DB-1:0] d, input logic r,
                       input logic w, input string nm);
        int  hi, line;
        bit  out_of_range;
        access(a, d, r, w, hi);
        line = int'((a / 64) % 1024);
        out_of_range = BC && (a >= 64'd65536);
        if (w && !out_of_range) model[line] = d;
        if (r) m_rd = out_of_range ? {DB{1'b1}} : (w ? d : model[line]);
        m_err = out_of_range;
        chk({nm, "_stall"}, DB'(hi), DB'(4));
        chk({nm, "_rdata"}, m_read_data, m_rd);
        chk({nm, "_err"}, DB'(m_error), DB'(m_err));
    endtask

    initial begin
        int            hi;
        logic [9:0]    pat;
        logic [63:0]   a;
        logic [DB-1:0] dead, a5, one, junk;
        a5   = {(DB/16){16'hA5A5}};
        one  = DB'(1);
        dead = DB'(16'hDEAD);
        vecs[0] = '{64'h40,    a5,          1'b0, 1'b1, '0,                      1'b0};
        vecs[1] = '{64'h40,    '0,          1'b1, 1'b0, a5,                      1'b0};
        vecs[2] = '{64'h40,    one,         1'b0, 1'b1, a5,                      1'b0};
        vecs[3] = '{64'h7F,    '0,          1'b1, 1'b0, one,                     1'b0};
        vecs[4] = '{64'h10040, '0,          1'b1, 1'b0, BC ? {DB{1'b1}} : one,   BC};
        vecs[5] = '{64'h80,    dead,        1'b1, 1'b1, dead,                    1'b0};
        vecs[6] = '{64'h80,    '0,          1'b1, 1'b0, dead,                    1'b0};
        vecs[7] = '{64'h100,   DB'(8'h55),  1'b0, 1'b1, dead,                    1'b0};
        vecs[8] = '{64'hC0,    DB'(16'h1111), 1'b0, 1'b1, dead,                  1'b0};

        rst = 1'b1; m_addr = '0; m_write_data = '0; m_read_en = 1'b0; m_write_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", DB'(m_stall), '0);
        chk("reset_rdata", m_read_data, '0);
        chk("reset_err", DB'(m_error), '0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            access(vecs[i].a, vecs[i].d, vecs[i].r, vecs[i].w, hi);
            chk($sformatf("vec%0d_stall", i), DB'(hi), DB'(4));
            chk($sformatf("vec%0d_rdata", i), m_read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), DB'(m_error), DB'(vecs[i].exp_err));
        end

        // read enable held across two accesses: busy-time enables ignored, one idle cycle between
        @(negedge clk);
        m_addr = 64'h40; m_read_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            pat[i] = m_stall;
        end
        m_read_en = 1'b0;
        chk("b2b_stall_pattern", DB'(pat), DB'(10'b0111101111));
        chk("b2b_rdata", m_read_data, one);

        // a write request raised while busy must not be taken
        junk = rnd();
        @(negedge clk);
        m_addr = 64'h80; m_read_en = 1'b1;
        @(posedge clk); #1;
        m_read_en = 1'b0;
        @(negedge clk);
        m_addr = 64'h100; m_write_data = junk; m_write_en = 1'b1;
        @(negedge clk);
        @(negedge clk) m_write_en = 1'b0;
        hi = 0;
        while (m_stall && hi < 20) begin
            hi++;
            @(posedge clk); #1;
        end
        chk("busy_ign_done", DB'(m_stall), '0);
        chk("busy_ign_rdata", m_read_data, dead);
        access(64'h100, '0, 1'b1, 1'b0, hi);
        chk("busy_ign_line", m_read_data, DB'(8'h55));

        // reset two cycles into a write discards it
        @(negedge clk);
        m_addr = 64'hC0; m_write_data = DB'(16'hBEEF); m_write_en = 1'b1;
        @(posedge clk); #1;
        m_write_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_stall", DB'(m_stall), '0);
        chk("rst_mid_rdata", m_read_data, '0);
        @(negedge clk) rst = 1'b0;
        access(64'hC0, '0, 1'b1, 1'b0, hi);
        chk("rst_mid_stall_cnt", DB'(hi), DB'(4));
        chk("rst_mid_line", m_read_data, DB'(16'h1111));

        // randomized traffic against the reference model
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_rd = '0; m_err = 1'b0;
        for (int l = 0; l < 16; l++) txn(64'(l) * 64, rnd(), 1'b0, 1'b1, "pre");
        for (int k = 0; k < 40; k++) begin
            int op;
            a = 64'($urandom_range(0, 15)) * 64 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a + (64'h10000 << $urandom_range(0, 40));
            op = $urandom_range(0, 2);
            txn(a, rnd(), op != 1, op != 0, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
